// File: rtl/ex_stage_if.sv
// ============================================================================
// Module   : ex_stage_if
// Brief    : ID/EX, MEM/WB and EX/MEM signal bundle for the execute stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ex_stage_if #(
    parameter int XLEN = 32,
    parameter int PCW  = 10
);
    logic [31:0]      de_inst;
    logic [PCW-1:0]   de_pc;
    logic [XLEN-1:0]  de_rs1;
    logic [XLEN-1:0]  de_rs2;
    logic [31:0]      mb_inst;
    logic [XLEN-1:0]  mb_alu;
    logic [XLEN-1:0]  mb_load;
    logic [XLEN-1:0]  alu_out;
    logic             zero;
    logic             overflow;
    logic             ex_stall;
    logic [31:0]      em_inst;
    logic [XLEN-1:0]  em_alu;
    logic [XLEN-1:0]  em_rs2;

    modport master (
        output de_inst, de_pc, de_rs1, de_rs2, mb_inst, mb_alu, mb_load,
        input  alu_out, zero, overflow, ex_stall, em_inst, em_alu, em_rs2
    );

    modport slave (
        input  de_inst, de_pc, de_rs1, de_rs2, mb_inst, mb_alu, mb_load,
        output alu_out, zero, overflow, ex_stall, em_inst, em_alu, em_rs2
    );
endinterface

`default_nettype wire

// File: rtl/ex_stage_unit.sv
// ============================================================================
// Module   : ex_stage_unit
// Brief    : RV32I execute stage: ALU, operand forwarding, load-use stall and
//            the EX/MEM register. Define ALU_MUL_EN to enable MUL/MULH*.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_stage_unit #(
    parameter int          XLEN = 32,
    parameter int          PCW  = 10,
    parameter logic [31:0] NOP  = 32'h0000_0013
) (
    input  wire logic  clk,
    input  wire logic  reset,
    ex_stage_if.slave  bus
);
    localparam logic [6:0] c_op_r     = 7'b0110011;
    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_br    = 7'b1100011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    localparam logic [6:0] c_f7_mul   = 7'b0000001;

    function automatic logic f_writes(input logic [6:0] op);
        return (op == c_op_r) || (op == c_op_imm) || (op == c_op_load) ||
               (op == c_op_lui) || (op == c_op_auipc) || (op == c_op_jal) ||
               (op == c_op_jalr);
    endfunction

    function automatic logic f_reads_rs1(input logic [6:0] op);
        return (op == c_op_r) || (op == c_op_imm) || (op == c_op_load) ||
               (op == c_op_store) || (op == c_op_br) || (op == c_op_jalr);
    endfunction

    function automatic logic f_reads_rs2(input logic [6:0] op);
        return (op == c_op_r) || (op == c_op_store) || (op == c_op_br);
    endfunction

    function automatic logic f_add_ovf(input logic [XLEN-1:0] a, b, s);
        return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
    endfunction

    function automatic logic f_sub_ovf(input logic [XLEN-1:0] a, b, d);
        return (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
    endfunction

    logic [31:0]     r_em_inst;
    logic [XLEN-1:0] r_em_alu;
    logic [XLEN-1:0] r_em_rs2;

    logic [6:0]      w_de_op, w_em_op, w_mb_op, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1, w_rs2, w_em_rd, w_mb_rd;
    logic            w_em_fwd, w_mb_fwd, w_stall;
    logic [XLEN-1:0] w_mb_val, w_op_a, w_op_b;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_u, w_pc;
    logic [XLEN-1:0] w_add_ab, w_sub_ab, w_add_ai, w_add_as;
    logic [XLEN-1:0] w_alu;
    logic            w_ovf;
    logic            w_unused_mb;

    assign w_de_op  = bus.de_inst[6:0];
    assign w_f3     = bus.de_inst[14:12];
    assign w_f7     = bus.de_inst[31:25];
    assign w_rs1    = bus.de_inst[19:15];
    assign w_rs2    = bus.de_inst[24:20];
    assign w_em_op  = r_em_inst[6:0];
    assign w_em_rd  = r_em_inst[11:7];
    assign w_mb_op  = bus.mb_inst[6:0];
    assign w_mb_rd  = bus.mb_inst[11:7];
    assign w_unused_mb = ^bus.mb_inst[31:12];

    // A load in EX/MEM has no data yet, so it never forwards; it stalls instead.
    assign w_em_fwd = f_writes(w_em_op) && (w_em_op != c_op_load) && (w_em_rd != 5'd0);
    assign w_mb_fwd = f_writes(w_mb_op) && (w_mb_rd != 5'd0);
    assign w_mb_val = (w_mb_op == c_op_load) ? bus.mb_load : bus.mb_alu;

    assign w_stall = (w_em_op == c_op_load) && (w_em_rd != 5'd0) &&
                     ((f_reads_rs1(w_de_op) && (w_rs1 == w_em_rd)) ||
                      (f_reads_rs2(w_de_op) && (w_rs2 == w_em_rd)));

    always_comb begin
        w_op_a = bus.de_rs1;
        if (w_em_fwd && (w_em_rd == w_rs1))
            w_op_a = r_em_alu;
        else if (w_mb_fwd && (w_mb_rd == w_rs1))
            w_op_a = w_mb_val;
    end

    always_comb begin
        w_op_b = bus.de_rs2;
        if (w_em_fwd && (w_em_rd == w_rs2))
            w_op_b = r_em_alu;
        else if (w_mb_fwd && (w_mb_rd == w_rs2))
            w_op_b = w_mb_val;
    end

    assign w_imm_i  = {{(XLEN-12){bus.de_inst[31]}}, bus.de_inst[31:20]};
    assign w_imm_s  = {{(XLEN-12){bus.de_inst[31]}}, bus.de_inst[31:25], bus.de_inst[11:7]};
    assign w_imm_u  = {bus.de_inst[31:12], 12'b0};
    assign w_pc     = {{(XLEN-PCW){1'b0}}, bus.de_pc};
    assign w_add_ab = w_op_a + w_op_b;
    assign w_sub_ab = w_op_a - w_op_b;
    assign w_add_ai = w_op_a + w_imm_i;
    assign w_add_as = w_op_a + w_imm_s;

`ifdef ALU_MUL_EN
    logic [2*XLEN-1:0] w_prod_ss, w_prod_su, w_prod_uu;
    assign w_prod_ss = {{XLEN{w_op_a[XLEN-1]}}, w_op_a} * {{XLEN{w_op_b[XLEN-1]}}, w_op_b};
    assign w_prod_su = {{XLEN{w_op_a[XLEN-1]}}, w_op_a} * {{XLEN{1'b0}}, w_op_b};
    assign w_prod_uu = {{XLEN{1'b0}}, w_op_a} * {{XLEN{1'b0}}, w_op_b};
`endif

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (w_de_op)
            c_op_r: begin
                if (w_f7 == c_f7_mul) begin
`ifdef ALU_MUL_EN
                    case (w_f3)
                        3'b000:  w_alu = w_prod_uu[XLEN-1:0];
                        3'b001:  w_alu = w_prod_ss[2*XLEN-1:XLEN];
                        3'b010:  w_alu = w_prod_su[2*XLEN-1:XLEN];
                        3'b011:  w_alu = w_prod_uu[2*XLEN-1:XLEN];
                        default: w_alu = '0;
                    endcase
`else
                    w_alu = '0;
`endif
                end else begin
                    case (w_f3)
                        3'b000: begin
                            if (w_f7[5]) begin
                                w_alu = w_sub_ab;
                                w_ovf = f_sub_ovf(w_op_a, w_op_b, w_sub_ab);
                            end else begin
                                w_alu = w_add_ab;
                                w_ovf = f_add_ovf(w_op_a, w_op_b, w_add_ab);
                            end
                        end
                        3'b001:  w_alu = w_op_a << w_op_b[4:0];
                        3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
                        3'b011:  w_alu = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
                        3'b100:  w_alu = w_op_a ^ w_op_b;
                        3'b101:  w_alu = w_f7[5] ? $unsigned($signed(w_op_a) >>> w_op_b[4:0])
                                                 : (w_op_a >> w_op_b[4:0]);
                        3'b110:  w_alu = w_op_a | w_op_b;
                        default: w_alu = w_op_a & w_op_b;
                    endcase
                end
            end
            c_op_imm: begin
                case (w_f3)
                    3'b000: begin
                        w_alu = w_add_ai;
                        w_ovf = f_add_ovf(w_op_a, w_imm_i, w_add_ai);
                    end
                    3'b001:  w_alu = w_op_a << w_imm_i[4:0];
                    3'b010:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_imm_i)};
                    3'b011:  w_alu = {{(XLEN-1){1'b0}}, w_op_a < w_imm_i};
                    3'b100:  w_alu = w_op_a ^ w_imm_i;
                    3'b101:  w_alu = w_f7[5] ? $unsigned($signed(w_op_a) >>> w_imm_i[4:0])
                                             : (w_op_a >> w_imm_i[4:0]);
                    3'b110:  w_alu = w_op_a | w_imm_i;
                    default: w_alu = w_op_a & w_imm_i;
                endcase
            end
            c_op_load: begin
                w_alu = w_add_ai;
                w_ovf = f_add_ovf(w_op_a, w_imm_i, w_add_ai);
            end
            c_op_store: begin
                w_alu = w_add_as;
                w_ovf = f_add_ovf(w_op_a, w_imm_s, w_add_as);
            end
            c_op_br: begin
                w_alu = w_sub_ab;
                w_ovf = f_sub_ovf(w_op_a, w_op_b, w_sub_ab);
            end
            c_op_lui:   w_alu = w_imm_u;
            c_op_auipc: w_alu = w_pc + w_imm_u;
            c_op_jal,
            c_op_jalr:  w_alu = w_pc + XLEN'(4);
            default:    w_alu = '0;
        endcase
    end

    // On a stall ID/EX is held upstream, so a bubble goes down instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_em_inst <= NOP;
            r_em_alu  <= '0;
            r_em_rs2  <= '0;
        end else if (w_stall) begin
            r_em_inst <= NOP;
            r_em_alu  <= '0;
            r_em_rs2  <= '0;
        end else begin
            r_em_inst <= bus.de_inst;
            r_em_alu  <= w_alu;
            r_em_rs2  <= w_op_b;
        end
    end

    assign bus.alu_out  = w_alu;
    assign bus.zero     = (w_alu == '0);
    assign bus.overflow = w_ovf;
    assign bus.ex_stall = w_stall;
    assign bus.em_inst  = r_em_inst;
    assign bus.em_alu   = r_em_alu;
    assign bus.em_rs2   = r_em_rs2;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_unit.sv
// ============================================================================
// Module   : tb_ex_stage_unit
// Brief    : Directed vector table plus forwarding/stall sequences for ex_stage_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage_unit;
    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_stage_if #(.XLEN(32), .PCW(10)) bus ();

    ex_stage_unit #(.XLEN(32), .PCW(10), .NOP(c_nop)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [9:0]  pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_alu;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [9:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.de_inst = inst;
        bus.de_pc   = pc;
        bus.de_rs1  = rs1;
        bus.de_rs2  = rs2;
    endtask

    task automatic drive_mb(input logic [31:0] inst, input logic [31:0] alu,
                            input logic [31:0] ld);
        bus.mb_inst = inst;
        bus.mb_alu  = alu;
        bus.mb_load = ld;
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mul_exp, mulhu_exp;
`ifdef ALU_MUL_EN
        mul_exp   = 32'h0000_000F;
        mulhu_exp = 32'hFFFF_FFFE;
`else
        mul_exp   = 32'h0;
        mulhu_exp = 32'h0;
`endif
        vecs.push_back('{"addi",      32'h0640_0093, 10'h000, 32'h0000_0000, 32'h0, 32'h0000_0064, 1'b0});
        vecs.push_back('{"add_ovf",   32'h0020_81B3, 10'h000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1});
        vecs.push_back('{"sub_zero",  32'h4020_81B3, 10'h000, 32'h0000_0005, 32'h5, 32'h0000_0000, 1'b0});
        vecs.push_back('{"sub_ovf",   32'h4020_81B3, 10'h000, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{"sra",       32'h4020_D1B3, 10'h000, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0});
        vecs.push_back('{"srl",       32'h0020_D1B3, 10'h000, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0});
        vecs.push_back('{"sll_5bit",  32'h0020_91B3, 10'h000, 32'h0000_0001, 32'h25, 32'h0000_0020, 1'b0});
        vecs.push_back('{"slt",       32'h0020_A1B3, 10'h000, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 1'b0});
        vecs.push_back('{"sltu",      32'h0020_B1B3, 10'h000, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 1'b0});
        vecs.push_back('{"xor",       32'h0020_C1B3, 10'h000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0});
        vecs.push_back('{"or",        32'h0020_E1B3, 10'h000, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0, 1'b0});
        vecs.push_back('{"and",       32'h0020_F1B3, 10'h000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0});
        vecs.push_back('{"addi_ovf",  32'hFFF0_8193, 10'h000, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{"srai",      32'h4040_D193, 10'h000, 32'h8000_0000, 32'h0, 32'hF800_0000, 1'b0});
        vecs.push_back('{"lui",       32'h1234_51B7, 10'h000, 32'h0, 32'h0, 32'h1234_5000, 1'b0});
        vecs.push_back('{"auipc",     32'h0000_1197, 10'h100, 32'h0, 32'h0, 32'h0000_1100, 1'b0});
        vecs.push_back('{"jal",       32'h0080_00EF, 10'h3FC, 32'h0, 32'h0, 32'h0000_0400, 1'b0});
        vecs.push_back('{"jalr",      32'h0001_00E7, 10'h200, 32'h0, 32'h0, 32'h0000_0204, 1'b0});
        vecs.push_back('{"lw_addr",   32'h0080_A183, 10'h000, 32'h0000_1000, 32'h0, 32'h0000_1008, 1'b0});
        vecs.push_back('{"sw_addr",   32'hFE20_AE23, 10'h000, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0FFC, 1'b0});
        vecs.push_back('{"beq_sub",   32'h0020_8063, 10'h000, 32'h0000_0003, 32'h5, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"unknown",   32'h0000_007F, 10'h000, 32'h1234_5678, 32'h1, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mul",       32'h0220_81B3, 10'h000, 32'h0000_0003, 32'h5, mul_exp, 1'b0});
        vecs.push_back('{"mulhu",     32'h0220_B1B3, 10'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mulhu_exp, 1'b0});

        drive(c_nop, 10'h0, 32'h0, 32'h0);
        drive_mb(c_nop, 32'h0, 32'h0);

        // Reset takes effect without a clock edge: load junk first, then reset mid-cycle.
        drive(32'h0640_0093, 10'h0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_em_inst", bus.em_inst, c_nop);
        chk("reset_em_alu",  bus.em_alu,  32'h0);
        chk("reset_em_rs2",  bus.em_rs2,  32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_reset();
            drive(vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk({vecs[i].name, "_alu"},   bus.alu_out, vecs[i].exp_alu);
            chk({vecs[i].name, "_ovf"},   {31'b0, bus.overflow}, {31'b0, vecs[i].exp_ovf});
            chk({vecs[i].name, "_zero"},  {31'b0, bus.zero}, {31'b0, vecs[i].exp_alu == 32'h0});
            chk({vecs[i].name, "_stall"}, {31'b0, bus.ex_stall}, 32'h0);
            step();
            chk({vecs[i].name, "_em_inst"}, bus.em_inst, vecs[i].inst);
            chk({vecs[i].name, "_em_alu"},  bus.em_alu,  vecs[i].exp_alu);
            chk({vecs[i].name, "_em_rs2"},  bus.em_rs2,  vecs[i].rs2);
        end

        // EX/MEM forwards rs1 (x1=100), MEM/WB forwards rs2 (x2=42) for a store.
        do_reset();
        drive(32'h0640_0093, 10'h0, 32'h0, 32'h0);
        step();
        chk("fwd_em_alu_pre", bus.em_alu, 32'd100);
        drive_mb(32'h02A0_0113, 32'd42, 32'h0);
        drive(32'h0020_A023, 10'h0, 32'h0, 32'h0);
        #1;
        chk("fwd_sw_alu",   bus.alu_out, 32'd100);
        chk("fwd_sw_stall", {31'b0, bus.ex_stall}, 32'h0);
        step();
        chk("fwd_sw_em_rs2", bus.em_rs2, 32'd42);
        chk("fwd_sw_em_alu", bus.em_alu, 32'd100);

        // Load-use: lw x3 then addi x3,x3,1 stalls once, then takes mb_load.
        do_reset();
        drive_mb(c_nop, 32'h0, 32'h0);
        drive(32'h0000_A183, 10'h0, 32'h40, 32'h0);
        step();
        drive(32'h0011_8193, 10'h0, 32'h0, 32'h0);
        #1;
        chk("lu_stall", {31'b0, bus.ex_stall}, 32'h1);
        step();
        chk("lu_bubble_inst", bus.em_inst, c_nop);
        chk("lu_bubble_alu",  bus.em_alu,  32'h0);
        chk("lu_bubble_rs2",  bus.em_rs2,  32'h0);
        drive_mb(32'h0000_A183, 32'h40, 32'd42);
        #1;
        chk("lu_stall_clear", {31'b0, bus.ex_stall}, 32'h0);
        chk("lu_alu",         bus.alu_out, 32'd43);
        step();
        chk("lu_em_inst", bus.em_inst, 32'h0011_8193);
        chk("lu_em_alu",  bus.em_alu,  32'd43);

        // Reset during a stall clears the register and removes the stall.
        drive_mb(c_nop, 32'h0, 32'h0);
        drive(32'h0000_A183, 10'h0, 32'h40, 32'h0);
        step();
        drive(32'h0011_8193, 10'h0, 32'h0, 32'h0);
        #1;
        chk("rst_stall_pre", {31'b0, bus.ex_stall}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_stall_inst", bus.em_inst, c_nop);
        chk("rst_stall_flag", {31'b0, bus.ex_stall}, 32'h0);
        reset = 1'b0;

        // Writes to x0 never forward.
        do_reset();
        drive(32'h0070_0013, 10'h0, 32'h0, 32'h0);
        step();
        drive_mb(32'h0090_0013, 32'd9, 32'h0);
        drive(32'h0000_01B3, 10'h0, 32'h11, 32'h22);
        #1;
        chk("x0_nofwd", bus.alu_out, 32'h33);

        // Both stages write x5: EX/MEM value wins on both operands.
        do_reset();
        drive_mb(c_nop, 32'h0, 32'h0);
        drive(32'h0550_0293, 10'h0, 32'h0, 32'h0);
        step();
        drive_mb(32'h0660_0293, 32'h66, 32'h0);
        drive(32'h0052_8333, 10'h0, 32'h0, 32'h0);
        #1;
        chk("prio_em_wins", bus.alu_out, 32'hAA);
        step();
        chk("prio_em_rs2", bus.em_rs2, 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
